// File: rtl/reg_array_scan_ctrl_pkg.sv
// reg_array_scan_ctrl_pkg: shared sizes, state/op encodings and row-mask helper
package reg_array_scan_ctrl_pkg;
  localparam int N = 4;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CELLS = ROWS * COLS;
  localparam int CW = $clog2(CELLS) + 1;
  localparam int SW_W = N * COLS;
  localparam int SEL_W = $clog2(CELLS);
  localparam int ROW_W = $clog2(ROWS);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_FIN  = 2'd3
  } state_t;
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_SCAN = 1'b1;
  function automatic logic [CELLS-1:0] row_mask(input logic [ROW_W-1:0] r);
    return {{(CELLS-COLS){1'b0}}, {COLS{1'b1}}} << (r * COLS);
  endfunction
endpackage

// File: rtl/reg_array_scan_ctrl_tally.sv
// reg_array_scan_ctrl_tally: saturating up-counter with sync clear and enable
module reg_array_scan_ctrl_tally #(
  parameter int n = 5,
  parameter int max = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [n-1:0] q
);
  // count up on enable, hold at max, clear wins
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en && q != n'(max)) q <= q + n'(1);
endmodule

// File: rtl/reg_array_scan_ctrl.sv
// reg_array_scan_ctrl: sequences row loads and a 16-cell compare scan of the register array
module reg_array_scan_ctrl
  import reg_array_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [ROW_W-1:0] row_sel,
  input  logic [SW_W-1:0]  sw,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [CELLS-1:0] reg_ld,
  output logic [SW_W-1:0]  reg_din,
  output logic [SEL_W-1:0] cell_sel,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    lt_cnt,
  output logic [CW-1:0]    eq_cnt,
  output logic [CW-1:0]    gt_cnt
);
  state_t state, nxt;
  logic [SEL_W-1:0] idx;
  logic [ROW_W-1:0] row_q;
  logic [CELLS-1:0] ld_nxt;
  logic tally, go_scan, cnt_clr, inc_lt, inc_eq, inc_gt;
  assign busy = state != ST_IDLE;
  assign cnt_clr = clr | go_scan;
  // state register
  always_ff @(posedge clk)
    if (clr) state <= ST_IDLE;
    else state <= nxt;
  // next state: load is one cycle, scan walks all cells, fin always returns to idle
  always_comb
    nxt = state == ST_IDLE ? (start ? (op == OP_LOAD ? ST_LOAD : ST_SCAN) : ST_IDLE) :
          state == ST_LOAD ? ST_FIN :
          state == ST_SCAN ? (idx == SEL_W'(CELLS-1) ? ST_FIN : ST_SCAN) : ST_IDLE;
  // output decode: next-cycle load mask, scan start, and one-hot tally by priority eq > lt > gt
  always_comb begin
    ld_nxt = state == ST_LOAD ? row_mask(row_q) : '0;
    go_scan = state == ST_IDLE && start && op == OP_SCAN;
    inc_eq = tally & cmp_eq;
    inc_lt = tally & ~cmp_eq & cmp_lt;
    inc_gt = tally & ~cmp_eq & ~cmp_lt & cmp_gt;
  end
  // request latch and cell index; index only runs in scan and wraps back to 0 on the last cell
  always_ff @(posedge clk)
    if (clr) begin
      row_q <= '0;
      reg_din <= '0;
      idx <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        row_q <= row_sel;
        reg_din <= sw;
      end
      idx <= state == ST_SCAN ? idx + SEL_W'(1) : '0;
    end
  // registered Moore outputs, one cycle behind the state that produces them
  always_ff @(posedge clk)
    if (clr) begin
      reg_ld <= '0;
      cell_sel <= '0;
      tally <= 1'b0;
      done <= 1'b0;
    end else begin
      reg_ld <= ld_nxt;
      cell_sel <= idx;
      tally <= state == ST_SCAN;
      done <= state == ST_FIN;
    end
  reg_array_scan_ctrl_tally #(.n(CW), .max(CELLS)) u_lt (.clk(clk), .clr(cnt_clr), .en(inc_lt), .q(lt_cnt));
  reg_array_scan_ctrl_tally #(.n(CW), .max(CELLS)) u_eq (.clk(clk), .clr(cnt_clr), .en(inc_eq), .q(eq_cnt));
  reg_array_scan_ctrl_tally #(.n(CW), .max(CELLS)) u_gt (.clk(clk), .clr(cnt_clr), .en(inc_gt), .q(gt_cnt));
endmodule
